blackjack_table: RTL

// - Multi-player blackjack round controller; successor to the single-player game with parametrised seat count, target and dealer rule.
// - Cards come from an external source over a req/valid handshake; soft aces are scored; each seat gets its own result.
// - Sits between the card source (LFSR/deck block) and the UI/display logic. Score outputs feed the 7-seg decoders.

---
 rtl/blackjack_table.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/blackjack_table.sv
// blackjack_table: multi-player blackjack round controller.
//   Deals two cards to every seat and the dealer, then serves seats in index
//   order (hit/stay), lets the dealer draw to DEALER_STAND and writes a result
//   per seat. Cards arrive from an external source over a req/valid handshake.
// Ports:
//   clk, reset (async, active-low)       clock and reset
//   start, hit, stay                     single-cycle control pulses
//   card_req / card_valid / card_value   card handshake (value 0 is rejected)
//   active_player                        seat being served, 0 outside PLAYER
//   player_scores, dealerScoreDisplay    soft-ace-aware scores
//   results                              per seat 00 none, 01 win, 10 lose, 11 tie
//   busy, done                           round in progress / round finished
module blackjack_table #(
    parameter int unsigned NUM_PLAYERS  = 2,
    parameter int unsigned TARGET       = 21,
    parameter int unsigned DEALER_STAND = 17,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           hit,
    input  logic                           stay,
    output logic                           card_req,
    input  logic                           card_valid,
    input  logic [3:0]                     card_value,
    output logic [2:0]                     active_player,
    output logic [NUM_PLAYERS*SCORE_W-1:0] player_scores,
    output logic [SCORE_W-1:0]             dealerScoreDisplay,
    output logic [2*NUM_PLAYERS-1:0]       results,
    output logic                           busy,
    output logic                           done
);

    // The dealer's hand lives in the slot after the last seat.
    localparam int unsigned Dealer = NUM_PLAYERS;
    localparam int unsigned Hands  = NUM_PLAYERS + 1;

    localparam logic [SCORE_W-1:0] TargetS = SCORE_W'(TARGET);
    localparam logic [SCORE_W-1:0] StandS  = SCORE_W'(DEALER_STAND);
    localparam logic [SCORE_W:0]   TargetW = (SCORE_W+1)'(TARGET);

    typedef enum logic [2:0] {
        StIdle, StDeal, StPlayer, StDealer, StResolve, StDone
    } state_e;

    state_e                  state_q;
    logic                    card_req_q;
    logic [2:0]              seat_q;
    logic [4:0]              deal_cnt_q;
    logic [SCORE_W-1:0]      hard_q [Hands];
    logic                    ace_q  [Hands];
    logic [2*NUM_PLAYERS-1:0] results_q;

    logic [3:0]         card_pts;
    logic               accept;
    logic [3:0]         tgt;
    logic [SCORE_W:0]   sum;
    logic [SCORE_W-1:0] new_hard;
    logic [SCORE_W-1:0] score [Hands];
    logic               all_bust;

    assign card_pts = (card_value > 4'd10) ? 4'd10 : card_value;
    assign accept   = card_req_q && card_valid && (card_value != 4'd0);

    // Hand that receives the card currently being requested.
    always_comb begin
        tgt = 4'(Dealer);
        case (state_q)
            StDeal: begin
                if (deal_cnt_q > 5'(Dealer)) tgt = 4'(deal_cnt_q - 5'(Hands));
                else                         tgt = deal_cnt_q[3:0];
            end
            StPlayer: tgt = {1'b0, seat_q};
            default:  tgt = 4'(Dealer);
        endcase
    end

    // Saturating hard-total add.
    assign sum      = {1'b0, hard_q[tgt]} + (SCORE_W+1)'(card_pts);
    assign new_hard = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

    // An ace counts 11 only while that keeps the hand within TARGET.
    always_comb begin
        for (int i = 0; i < Hands; i++) begin
            if (ace_q[i] && (({1'b0, hard_q[i]} + (SCORE_W+1)'(10)) <= TargetW))
                score[i] = hard_q[i] + SCORE_W'(10);
            else
                score[i] = hard_q[i];
        end
    end

    always_comb begin
        all_bust = 1'b1;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (score[i] <= TargetS) all_bust = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            card_req_q <= 1'b0;
            seat_q     <= 3'd0;
            deal_cnt_q <= 5'd0;
            results_q  <= '0;
            for (int i = 0; i < Hands; i++) begin
                hard_q[i] <= '0;
                ace_q[i]  <= 1'b0;
            end
        end else begin
            if (accept) begin
                hard_q[tgt] <= new_hard;
                if (card_pts == 4'd1) ace_q[tgt] <= 1'b1;
                card_req_q <= 1'b0;
            end
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        for (int i = 0; i < Hands; i++) begin
                            hard_q[i] <= '0;
                            ace_q[i]  <= 1'b0;
                        end
                        results_q  <= '0;
                        deal_cnt_q <= 5'd0;
                        card_req_q <= 1'b1;
                        state_q    <= StDeal;
                    end
                end
                StDeal: begin
                    if (accept) begin
                        deal_cnt_q <= deal_cnt_q + 5'd1;
                    end else if (!card_req_q) begin
                        if (deal_cnt_q == 5'(2 * Hands)) begin
                            seat_q  <= 3'd0;
                            state_q <= StPlayer;
                        end else begin
                            card_req_q <= 1'b1;
                        end
                    end
                end
                StPlayer: begin
                    // Inputs are ignored while a card is outstanding; stay beats hit.
                    if (!card_req_q) begin
                        if (stay || (score[seat_q] >= TargetS)) begin
                            if (seat_q == 3'(NUM_PLAYERS - 1)) state_q <= StDealer;
                            else                               seat_q  <= seat_q + 3'd1;
                        end else if (hit) begin
                            card_req_q <= 1'b1;
                        end
                    end
                end
                StDealer: begin
                    if (!card_req_q) begin
                        if (all_bust || (score[Dealer] >= StandS)) state_q <= StResolve;
                        else                                       card_req_q <= 1'b1;
                    end
                end
                StResolve: begin
                    for (int i = 0; i < NUM_PLAYERS; i++) begin
                        if (score[i] > TargetS)            results_q[2*i +: 2] <= 2'b10;
                        else if (score[Dealer] > TargetS)  results_q[2*i +: 2] <= 2'b01;
                        else if (score[i] > score[Dealer]) results_q[2*i +: 2] <= 2'b01;
                        else if (score[i] < score[Dealer]) results_q[2*i +: 2] <= 2'b10;
                        else                               results_q[2*i +: 2] <= 2'b11;
                    end
                    state_q <= StDone;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign card_req           = card_req_q;
    assign results            = results_q;
    assign dealerScoreDisplay = score[Dealer];
    assign busy               = (state_q == StDeal) || (state_q == StPlayer) ||
                                (state_q == StDealer) || (state_q == StResolve);
    assign done               = (state_q == StDone);
    assign active_player      = (state_q == StPlayer) ? seat_q : 3'd0;

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
        assign player_scores[g*SCORE_W +: SCORE_W] = score[g];
    end

endmodule
